sdp_ram_be: RTL

Parametrised simple dual-port RAM with one write port and one read port. It adds per-byte write enables, a selectable 1- or 2-cycle read pipeline, a defined read-during-write policy and a hardware memory-clear sequence after reset. It is the general-purpose buffer memory for the memories library, used wherever a block needs independent concurrent read and write access.

---
 rtl/sdp_ram_be.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: one write port with per-byte enables, one read port with a
// 1- or 2-cycle pipeline, selectable read-during-write policy and a post-reset clear.
module sdp_ram_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int DEPTH          = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             blk_select,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             busy
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic CLEAR_EN = (CLEAR_ON_RESET != 0);
    localparam logic RDW_EN   = (RDW_MODE != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   clr_addr_reg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q_reg;

    logic                    clearing;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_accept;
    logic                    rd_accept;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NUM_BYTES-1:0]    mem_wbe;

    logic                    s1_valid_reg;
    logic                    s1_oob_reg;
    logic                    s1_hit_reg;
    logic [NUM_BYTES-1:0]    s1_wbe_reg;
    logic [DATA_WIDTH-1:0]   s1_wdata_reg;
    logic [DATA_WIDTH-1:0]   s1_data;

    // busy also covers the reset cycles themselves so both ports stay blocked throughout
    assign busy     = (state_reg == CLEAR) | (rst & CLEAR_EN);
    assign clearing = (state_reg == CLEAR) & ~rst;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
    assign wr_accept   = blk_select & wr_en & ~busy & ~rst & wr_in_range;
    assign rd_accept   = blk_select & rd_en & ~busy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CLEAR_EN ? CLEAR : IDLE;
            clr_addr_reg <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + ADDR_WIDTH'(1);
                    if (clr_addr_reg == LAST_ADDR) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The clear sequence and user writes share the single physical write port
    always_comb begin
        mem_we    = clearing | wr_accept;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (clearing) begin
            mem_waddr = clr_addr_reg;
            mem_wdata = '0;
            mem_wbe   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (mem_wbe[b]) begin
                    mem[mem_waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (rd_accept & rd_in_range) begin
            ram_q_reg <= mem[rd_addr];
        end
    end

    // Out-of-range flag resets high so rd_data reads as zero until the first real read
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_oob_reg   <= 1'b1;
            s1_hit_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= rd_accept;
            if (rd_accept) begin
                s1_oob_reg   <= ~rd_in_range;
                s1_hit_reg   <= RDW_EN & wr_accept & (wr_addr == rd_addr);
                s1_wbe_reg   <= wr_be;
                s1_wdata_reg <= wr_data;
            end
        end
    end

    // Write-first merge is applied after the RAM register, lane by lane
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign s1_data[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                s1_oob_reg                      ? '0 :
                (s1_hit_reg && s1_wbe_reg[gi])  ? s1_wdata_reg[gi*BYTE_WIDTH +: BYTE_WIDTH] :
                                                  ram_q_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd_data_reg;
            logic                  rd_valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        rd_data_reg <= s1_data;
                    end
                end
            end

            assign rd_data  = rd_data_reg;
            assign rd_valid = rd_valid_reg;
        end else begin : g_lat1
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid_reg;
        end
    endgenerate

endmodule
